// File: rtl/mbist_multi_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mbist_multi_serial_ctrl
// Description : Serial IR/DR test-access controller for NCH memory-BIST
//               channels. Per-channel enables (COMMAND), GO/DONE readout
//               (RESULT), per-channel watchdog timeout (DIAG) and aggregated
//               all_done / all_go flags. Single clock (MCK).
// Revision    : 1.0 - initial release
// ============================================================================

module mbist_multi_serial_ctrl #(
  parameter int NCH     = 4,
  parameter int IR_W    = 2,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic           MCK,
  input  logic           RSTN,
  input  logic           SRST,
  input  logic           SEN,
  input  logic           SDI,
  output logic           SDO,
  output logic [NCH-1:0] bist_men,
  input  logic [NCH-1:0] bist_go,
  input  logic [NCH-1:0] bist_done,
  output logic           all_done,
  output logic           all_go
);

  // Widest DR is RESULT (two bits per channel); the bit counter must reach
  // one past the longest shift so over-length DR scans can be told apart.
  localparam int DRW     = 2 * NCH;
  localparam int CNT_MAX = ((DRW > IR_W) ? DRW : IR_W) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] c_ir_last = CNT_W'(IR_W - 1);
  localparam logic [TO_W-1:0]  c_wd_last = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] c_st_idle     = 2'd0;
  localparam logic [1:0] c_st_shift_ir = 2'd1;
  localparam logic [1:0] c_st_wait_dr  = 2'd2;
  localparam logic [1:0] c_st_shift_dr = 2'd3;

  logic [1:0]       r_state;
  logic [IR_W-1:0]  r_ir;
  logic [IR_W-1:0]  r_ir_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [DRW-1:0]   r_dr_sh;
  logic [NCH-1:0]   r_men;
  logic [NCH-1:0]   r_timeout;
  logic [TO_W-1:0]  r_wd [NCH];
  logic             r_all_done;
  logic             r_all_go;

  logic [IR_W-1:0]  w_ir_new;
  logic [DRW-1:0]   w_cap;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_len_m1;
  logic [DRW-1:0]   w_dr_shift;
  logic             w_upd;
  logic [NCH-1:0]   w_men_nxt;
  logic [NCH-1:0]   w_done_eff;
  logic [NCH-1:0]   w_go_eff;

  // DR length selected by an instruction; unknown IDs behave as BYPASS.
  function automatic logic [CNT_W-1:0] dr_len(input logic [IR_W-1:0] id);
    case (32'(id))
      32'd1:   dr_len = CNT_W'(NCH);
      32'd2:   dr_len = CNT_W'(DRW);
      32'd3:   dr_len = CNT_W'(NCH);
      default: dr_len = CNT_W'(1);
    endcase
  endfunction

  // A timed-out channel counts as done but never as passing.
  assign w_done_eff = bist_done | r_timeout;
  assign w_go_eff   = bist_go & bist_done & ~r_timeout;

  // IR bits land at their own index; the last bit comes straight from SDI.
  always_comb begin
    w_ir_new           = r_ir_sh;
    w_ir_new[IR_W-1]   = SDI;
  end

  // Capture value for the instruction being completed on this edge.
  always_comb begin
    w_cap = '0;
    case (32'(w_ir_new))
      32'd1: w_cap[NCH-1:0] = r_men;
      32'd2: begin
        for (int i = 0; i < NCH; i++) begin
          w_cap[2*i]   = w_done_eff[i];
          w_cap[2*i+1] = w_go_eff[i];
        end
      end
      32'd3: w_cap[NCH-1:0] = r_timeout;
      default: ;
    endcase
  end

  // Right shift over the active DR length only; bits above it are untouched.
  always_comb begin
    w_len      = dr_len(r_ir);
    w_len_m1   = w_len - CNT_W'(1);
    w_dr_shift = r_dr_sh;
    for (int j = 0; j < DRW - 1; j++) begin
      if (CNT_W'(j) == w_len_m1)
        w_dr_shift[j] = SDI;
      else if (CNT_W'(j) < w_len_m1)
        w_dr_shift[j] = r_dr_sh[j+1];
    end
    if (CNT_W'(DRW - 1) == w_len_m1)
      w_dr_shift[DRW-1] = SDI;
  end

  // COMMAND update only on an exact-length scan ending with SEN low.
  assign w_upd     = SRST && (r_state == c_st_shift_dr) && !SEN &&
                     (r_cnt == w_len) && (r_ir == IR_W'(1));
  assign w_men_nxt = w_upd ? r_dr_sh[NCH-1:0] : r_men;

  // Serial protocol FSM: IR assembly, DR capture/shift.
  always_ff @(posedge MCK) begin
    if (!RSTN) begin
      r_state <= c_st_idle;
      r_ir    <= '0;
      r_ir_sh <= '0;
      r_cnt   <= '0;
      r_dr_sh <= '0;
    end else if (!SRST) begin
      r_state <= c_st_idle;
      r_ir    <= '0;
      r_cnt   <= '0;
      r_dr_sh <= '0;
    end else begin
      case (r_state)
        // IDLE always holds cnt=0, so it shares the IR shift path.
        c_st_idle, c_st_shift_ir: begin
          if (SEN) begin
            for (int j = 0; j < IR_W; j++) begin
              if (CNT_W'(j) == r_cnt) r_ir_sh[j] <= SDI;
            end
            if (r_cnt == c_ir_last) begin
              r_ir    <= w_ir_new;
              r_dr_sh <= w_cap;
              r_cnt   <= '0;
              r_state <= c_st_wait_dr;
            end else begin
              r_cnt   <= r_cnt + CNT_W'(1);
              r_state <= c_st_shift_ir;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= c_st_idle;
          end
        end
        c_st_wait_dr: begin
          if (SEN) begin
            r_dr_sh <= w_dr_shift;
            r_cnt   <= CNT_W'(1);
            r_state <= c_st_shift_dr;
          end
        end
        c_st_shift_dr: begin
          if (SEN) begin
            r_dr_sh <= w_dr_shift;
            if (r_cnt <= w_len) r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt   <= '0;
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  // Channel enable register, written by COMMAND updates.
  always_ff @(posedge MCK) begin
    if (!RSTN) r_men <= '0;
    else       r_men <= w_men_nxt;
  end

  // Per-channel watchdog; a same-edge disable wins over a timeout set.
  always_ff @(posedge MCK) begin
    if (!RSTN) begin
      r_timeout <= '0;
      for (int i = 0; i < NCH; i++) r_wd[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!r_men[i] || !w_men_nxt[i]) begin
          r_wd[i]      <= '0;
          r_timeout[i] <= 1'b0;
        end else if (!bist_done[i] && !r_timeout[i]) begin
          r_wd[i] <= r_wd[i] + TO_W'(1);
          if (r_wd[i] == c_wd_last) r_timeout[i] <= 1'b1;
        end
      end
    end
  end

  // Aggregate flags over enabled channels only.
  always_ff @(posedge MCK) begin
    if (!RSTN) begin
      r_all_done <= 1'b0;
      r_all_go   <= 1'b0;
    end else begin
      r_all_done <= (|r_men) && (&(w_done_eff | ~r_men));
      r_all_go   <= (|r_men) && (&(w_done_eff | ~r_men)) && (&(w_go_eff | ~r_men));
    end
  end

  assign SDO      = ((r_state == c_st_wait_dr) || (r_state == c_st_shift_dr)) ? r_dr_sh[0] : 1'b0;
  assign bist_men = r_men;
  assign all_done = r_all_done;
  assign all_go   = r_all_go;

endmodule

`default_nettype wire
